// File: rtl/bs_job_ctrl.sv
// Host-side job initiator for the Black-Scholes processor: loads the job
// constants, sequences RUN/ACK handshakes n_runs times and buffers every
// result in a small FIFO for the host to drain.
module bs_job_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned RES_DEPTH      = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [31:0]                 job_k,
    input  logic [31:0]                 job_c1,
    input  logic [31:0]                 job_c2,
    input  logic [31:0]                 job_c3,
    input  logic [7:0]                  n_runs,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic                        res_valid,
    output logic [31:0]                 res_data,
    input  logic                        res_rd,
    output logic [$clog2(RES_DEPTH):0]  res_count,
    output logic [31:0]                 proc_constK,
    output logic [31:0]                 proc_const1,
    output logic [31:0]                 proc_const2,
    output logic [31:0]                 proc_const3,
    output logic [3:0]                  proc_cmd,
    input  logic [3:0]                  proc_status,
    input  logic [31:0]                 proc_dout
);

    localparam int unsigned PTR_W = $clog2(RES_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [3:0] CMD_NOP     = 4'd0;
    localparam logic [3:0] CMD_RUN     = 4'd1;
    localparam logic [3:0] CMD_ACK     = 4'd2;
    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_RUNNING  = 4'd1;
    localparam logic [3:0] ST_COMPLETE = 4'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_WAIT,
        S_ACK,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state, state_d;
    logic [7:0]         run_target;
    logic [7:0]         runs_done;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               tmo_run;
    logic               tmo_hit;
    logic               illegal;
    logic               load_job;
    logic               push;
    logic               pop;
    logic               full;
    logic               busy_d;
    logic               done_d;
    logic               error_d;
    logic [3:0]         cmd_d;

    logic [31:0]        mem [RES_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    // Next-state, FIFO push and registered-output precompute
    always_comb begin
        state_d  = state;
        tmo_run  = 1'b0;
        load_job = 1'b0;
        push     = 1'b0;
        illegal  = (proc_status > ST_COMPLETE);
        tmo_hit  = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
        full     = (res_count == CNT_W'(RES_DEPTH));

        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    load_job = 1'b1;
                    state_d  = (n_runs == 8'd0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: state_d = S_RUN;
            S_RUN: begin
                tmo_run = 1'b1;
                if (illegal)                         state_d = S_ERR;
                else if (proc_status == ST_RUNNING)  state_d = S_WAIT;
                else if (tmo_hit)                    state_d = S_ERR;
            end
            S_WAIT: begin
                if (illegal) begin
                    state_d = S_ERR;
                end else if (proc_status == ST_COMPLETE) begin
                    // Full FIFO: processor keeps holding COMPLETE, timeout frozen
                    if (!full) begin
                        push    = 1'b1;
                        state_d = S_ACK;
                    end
                end else begin
                    tmo_run = 1'b1;
                    if (tmo_hit) state_d = S_ERR;
                end
            end
            S_ACK: begin
                tmo_run = 1'b1;
                if (illegal)                      state_d = S_ERR;
                else if (proc_status == ST_IDLE)  state_d = (runs_done < run_target) ? S_LOAD : S_DONE;
                else if (tmo_hit)                 state_d = S_ERR;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d  = (state_d inside {S_LOAD, S_RUN, S_WAIT, S_ACK});
        done_d  = (state_d == S_DONE);
        error_d = (state_d == S_ERR);
        cmd_d   = (state_d == S_RUN) ? CMD_RUN :
                  (state_d == S_ACK) ? CMD_ACK : CMD_NOP;
    end

    // State, registered outputs, job registers and counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            proc_cmd    <= CMD_NOP;
            proc_constK <= 32'd0;
            proc_const1 <= 32'd0;
            proc_const2 <= 32'd0;
            proc_const3 <= 32'd0;
            run_target  <= 8'd0;
            runs_done   <= 8'd0;
            tmo_cnt     <= '0;
        end else begin
            state    <= state_d;
            busy     <= busy_d;
            done     <= done_d;
            error    <= error_d;
            proc_cmd <= cmd_d;
            if (load_job) begin
                proc_constK <= job_k;
                proc_const1 <= job_c1;
                proc_const2 <= job_c2;
                proc_const3 <= job_c3;
                run_target  <= n_runs;
                runs_done   <= 8'd0;
            end else if (push) begin
                runs_done <= runs_done + 8'd1;
            end
            if (state_d != state) tmo_cnt <= '0;
            else if (tmo_run)     tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    assign pop = res_rd && (res_count != CNT_W'(0));

    // Result FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            res_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      res_count <= res_count + CNT_W'(1);
            else if (pop && !push) res_count <= res_count - CNT_W'(1);
        end
    end

    // Result FIFO storage
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= proc_dout;
    end

    assign res_valid = (res_count != CNT_W'(0));
    assign res_data  = res_valid ? mem[rd_ptr] : 32'd0;

endmodule

// File: tb/tb_bs_job_ctrl.sv
// Directed bench for bs_job_ctrl with a behavioural processor model and a
// result scoreboard.
module tb_bs_job_ctrl;

    localparam int unsigned TMO    = 1024;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned PM_LAT = 49;
    localparam int unsigned LIMIT  = 3000;

    localparam int PM_NORMAL  = 0;
    localparam int PM_STICK   = 1;
    localparam int PM_ILLEGAL = 2;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] job_k, job_c1, job_c2, job_c3;
    logic [7:0]  n_runs;
    logic        busy, done, error, res_valid, res_rd;
    logic [31:0] res_data;
    logic [3:0]  res_count;
    logic [31:0] proc_constK, proc_const1, proc_const2, proc_const3;
    logic [3:0]  proc_cmd;
    logic [3:0]  proc_status;
    logic [31:0] proc_dout;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] dout_q[$];
    int          pm_mode = PM_NORMAL;
    logic        pm_clear = 1'b0;
    int          pm_cnt;
    logic [31:0] pm_k;
    logic        track_max = 1'b0;
    int          max_cnt = 0;

    bs_job_ctrl #(.TIMEOUT_CYCLES(TMO), .RES_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start),
        .job_k(job_k), .job_c1(job_c1), .job_c2(job_c2), .job_c3(job_c3),
        .n_runs(n_runs), .busy(busy), .done(done), .error(error),
        .res_valid(res_valid), .res_data(res_data), .res_rd(res_rd),
        .res_count(res_count),
        .proc_constK(proc_constK), .proc_const1(proc_const1),
        .proc_const2(proc_const2), .proc_const3(proc_const3),
        .proc_cmd(proc_cmd), .proc_status(proc_status), .proc_dout(proc_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Processor model: IDLE -> RUNNING on RUN, COMPLETE after latency, IDLE on ACK
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            proc_status <= 4'd0;
            proc_dout   <= 32'd0;
            pm_cnt      <= 0;
            pm_k        <= 32'd0;
        end else if (pm_clear) begin
            proc_status <= 4'd0;
            pm_cnt      <= 0;
        end else begin
            case (proc_status)
                4'd0: if (proc_cmd == 4'd1) begin
                    proc_status <= 4'd1;
                    pm_cnt      <= 1;
                    pm_k        <= proc_constK;
                end
                4'd1: begin
                    pm_cnt <= pm_cnt + 1;
                    if (pm_mode == PM_ILLEGAL && pm_cnt >= 3) begin
                        proc_status <= 4'd5;
                    end else if (pm_mode == PM_NORMAL && pm_cnt >= PM_LAT - 1) begin
                        proc_status <= 4'd2;
                        if (dout_q.size() != 0) proc_dout <= dout_q.pop_front();
                        else                    proc_dout <= 32'hBAD0_0BAD;
                    end
                end
                4'd2: if (proc_cmd == 4'd2) proc_status <= 4'd0;
                default: ;
            endcase
        end
    end

    // Scoreboard: every popped FIFO head is compared with the oldest expected result
    always @(negedge clk) begin
        if (!reset && res_rd && res_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL fifo_extra observed=0x%08h expected=none", res_data);
            end else begin
                check("fifo_data", res_data, exp_q.pop_front());
            end
        end
        if (track_max && int'(res_count) > max_cnt) max_cnt = int'(res_count);
    end

    task automatic start_job(input logic [31:0] k, input logic [31:0] c1,
                             input logic [31:0] c2, input logic [31:0] c3,
                             input logic [7:0] n);
        job_k  = k;
        job_c1 = c1;
        job_c2 = c2;
        job_c3 = c3;
        n_runs = n;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_cmd(input logic [3:0] val, input bit eq, input string tag);
        int n;
        n = 0;
        while (((proc_cmd == val) != eq) && n < LIMIT) begin
            tick();
            n++;
        end
        check({tag, "_reached"}, 32'(n < LIMIT), 32'd1);
    endtask

    task automatic wait_count(input int val, input string tag);
        int n;
        n = 0;
        while (int'(res_count) != val && n < LIMIT) begin
            tick();
            n++;
        end
        check({tag, "_reached"}, 32'(n < LIMIT), 32'd1);
    endtask

    task automatic wait_end(input string tag);
        int n;
        n = 0;
        while (!done && !error && n < LIMIT) begin
            tick();
            n++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_error"}, 32'(error), 32'd0);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        res_rd = 1'b1;
        while (res_valid && n < 64) begin
            tick();
            n++;
        end
        res_rd = 1'b0;
        check({tag, "_all_read"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        res_rd = 1'b0;
        job_k  = 32'd0;
        job_c1 = 32'd0;
        job_c2 = 32'd0;
        job_c3 = 32'd0;
        n_runs = 8'd0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_cmd", 32'(proc_cmd), 32'd0);
        check("rst_count", 32'(res_count), 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_constK", proc_constK, 32'd0);
        reset = 1'b0;
        tick();

        // Single run
        dout_q.push_back(32'h1234_5678);
        exp_q.push_back(32'h1234_5678);
        start_job(32'h42C8_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 8'd1);
        check("t1_load_cmd", 32'(proc_cmd), 32'd0);
        check("t1_load_busy", 32'(busy), 32'd1);
        tick();
        check("t1_run_cmd_t2", 32'(proc_cmd), 32'd1);
        check("t1_constK", proc_constK, 32'h42C8_0000);
        check("t1_const3", proc_const3, 32'h3F80_0000);
        wait_cmd(4'd2, 1'b1, "t1_ack");
        check("t1_ack_count", 32'(res_count), 32'd1);
        check("t1_ack_status", 32'(proc_status), 32'd2);
        wait_cmd(4'd2, 1'b0, "t1_ack_end");
        check("t1_ack_released_on_idle", 32'(proc_status), 32'd0);
        check("t1_done", 32'(done), 32'd1);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_count", 32'(res_count), 32'd1);
        check("t1_head", res_data, 32'h1234_5678);
        check("t1_model_k", pm_k, 32'h42C8_0000);
        drain("t1");

        // Multi-run with FIFO stall
        for (int i = 1; i <= 10; i++) begin
            dout_q.push_back(32'(i));
            exp_q.push_back(32'(i));
        end
        start_job(32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000, 8'd10);
        wait_count(8, "t2_full");
        repeat (1500) tick();
        check("t2_stall_error", 32'(error), 32'd0);
        check("t2_stall_busy", 32'(busy), 32'd1);
        check("t2_stall_status", 32'(proc_status), 32'd2);
        check("t2_stall_cmd", 32'(proc_cmd), 32'd0);
        check("t2_stall_count", 32'(res_count), 32'd8);
        res_rd = 1'b1;
        tick();
        tick();
        res_rd = 1'b0;
        wait_end("t2");
        check("t2_count", 32'(res_count), 32'd8);
        drain("t2");

        // Simultaneous push/pop
        for (int i = 0; i < 4; i++) begin
            dout_q.push_back(32'hA0 + 32'(i));
            exp_q.push_back(32'hA0 + 32'(i));
        end
        max_cnt   = 0;
        track_max = 1'b1;
        res_rd    = 1'b1;
        start_job(32'h4100_0000, 32'h4110_0000, 32'h4120_0000, 32'h4130_0000, 8'd4);
        wait_end("t3");
        tick();
        res_rd    = 1'b0;
        track_max = 1'b0;
        check("t3_max_count", 32'(max_cnt), 32'd1);
        check("t3_all_read", 32'(exp_q.size()), 32'd0);

        // Timeout from WAIT
        pm_mode = PM_STICK;
        start_job(32'h4200_0000, 32'h4210_0000, 32'h4220_0000, 32'h4230_0000, 8'd1);
        tick();
        check("t4_run_cmd", 32'(proc_cmd), 32'd1);
        wait_cmd(4'd1, 1'b0, "t4_wait_entry");
        repeat (TMO - 1) tick();
        check("t4_error_early", 32'(error), 32'd0);
        tick();
        check("t4_error", 32'(error), 32'd1);
        check("t4_cmd", 32'(proc_cmd), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        pm_clear = 1'b1;
        tick();
        pm_clear = 1'b0;
        pm_mode  = PM_NORMAL;
        dout_q.push_back(32'hC0DE_0001);
        exp_q.push_back(32'hC0DE_0001);
        start_job(32'h4240_0000, 32'h4250_0000, 32'h4260_0000, 32'h4270_0000, 8'd1);
        check("t4_error_cleared", 32'(error), 32'd0);
        wait_end("t4_rerun");
        drain("t4");

        // n_runs = 0
        start_job(32'h4300_0000, 32'h4310_0000, 32'h4320_0000, 32'h4330_0000, 8'd0);
        check("t5_zero_done", 32'(done), 32'd1);
        check("t5_zero_busy", 32'(busy), 32'd0);
        repeat (5) tick();
        check("t5_zero_cmd", 32'(proc_cmd), 32'd0);
        check("t5_zero_status", 32'(proc_status), 32'd0);
        check("t5_zero_count", 32'(res_count), 32'd0);

        // Illegal status in WAIT
        pm_mode = PM_ILLEGAL;
        start_job(32'h4400_0000, 32'h4410_0000, 32'h4420_0000, 32'h4430_0000, 8'd1);
        wait_cmd(4'd1, 1'b1, "t5_ill_run");
        wait_cmd(4'd1, 1'b0, "t5_ill_wait");
        repeat (10) tick();
        check("t5_ill_error", 32'(error), 32'd1);
        check("t5_ill_cmd", 32'(proc_cmd), 32'd0);
        check("t5_ill_count", 32'(res_count), 32'd0);
        pm_clear = 1'b1;
        tick();
        pm_clear = 1'b0;
        pm_mode  = PM_NORMAL;

        // Start while busy is ignored
        dout_q.push_back(32'h0000_BEEF);
        exp_q.push_back(32'h0000_BEEF);
        start_job(32'h4500_0000, 32'h4510_0000, 32'h4520_0000, 32'h4530_0000, 8'd1);
        wait_cmd(4'd1, 1'b1, "t5_busy_run");
        wait_cmd(4'd1, 1'b0, "t5_busy_wait");
        start_job(32'h4600_0000, 32'h4610_0000, 32'h4620_0000, 32'h4630_0000, 8'd5);
        check("t5_busy_constK", proc_constK, 32'h4500_0000);
        check("t5_busy_const1", proc_const1, 32'h4510_0000);
        check("t5_busy_busy", 32'(busy), 32'd1);
        wait_end("t5_busy");
        check("t5_busy_one_run", 32'(res_count), 32'd1);
        drain("t5_busy");

        // Reset during WAIT of run 2 of 3
        for (int i = 0; i < 3; i++) begin
            dout_q.push_back(32'h31 + 32'(i));
            exp_q.push_back(32'h31 + 32'(i));
        end
        start_job(32'h4700_0000, 32'h4710_0000, 32'h4720_0000, 32'h4730_0000, 8'd3);
        wait_count(1, "t6_first");
        wait_cmd(4'd1, 1'b1, "t6_run2");
        wait_cmd(4'd1, 1'b0, "t6_wait2");
        #3;
        reset = 1'b1;
        #1;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_error", 32'(error), 32'd0);
        check("t6_cmd", 32'(proc_cmd), 32'd0);
        check("t6_count", 32'(res_count), 32'd0);
        check("t6_valid", 32'(res_valid), 32'd0);
        check("t6_data", res_data, 32'd0);
        check("t6_constK", proc_constK, 32'd0);
        exp_q.delete();
        dout_q.delete();
        tick();
        tick();
        reset = 1'b0;
        tick();
        dout_q.push_back(32'h51);
        dout_q.push_back(32'h52);
        exp_q.push_back(32'h51);
        exp_q.push_back(32'h52);
        start_job(32'h4800_0000, 32'h4810_0000, 32'h4820_0000, 32'h4830_0000, 8'd2);
        wait_end("t6_after");
        check("t6_after_count", 32'(res_count), 32'd2);
        drain("t6_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
